cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the two result producers: the ALU result path and the load/store buffer.
- Each source owns a small FIFO. A round-robin arbiter drains one entry per cycle onto a registered broadcast bus.
- The bus is consumed by the ROB, the reservation station wakeup logic and the LSB.
- Producers see backpressure through per-source ready signals.

---
 rtl/cdb_arbiter_pkg.sv | 18 +
 rtl/cdb_fifo.sv | 63 ++++++
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default ROB tag width, broadcast payload width and
// the round-robin priority encoding used by cdb_arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned ROB_W = 4;
    localparam int unsigned CDB_W = ROB_W + 32;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSB = 1'b1
    } prio_e;

    // After a grant, priority moves to the source that lost.
    function automatic prio_e prio_flip(input prio_e p);
        return (p == PRIO_ALU) ? PRIO_LSB : PRIO_ALU;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO holding one producer's pending CDB payloads.
// DEPTH must be a power of two so the pointers wrap naturally.
module cdb_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk_in) begin
        if (w_push && !rst_in && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between the ALU and LSB result
// FIFOs. Define CDB_BYPASS_EN to let a result skip an empty FIFO (latency 1).
module cdb_arbiter #(
    parameter int unsigned ROB_W      = cdb_arbiter_pkg::ROB_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_value,
    output logic             alu_ready,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_value,
    output logic             lsb_ready,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_value
);

    import cdb_arbiter_pkg::*;

    localparam int unsigned PAY_W = ROB_W + 32;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PAY_W-1:0] w_alu_head;
    logic [PAY_W-1:0] w_lsb_head;
    logic [CNT_W-1:0] w_alu_count;
    logic [CNT_W-1:0] w_lsb_count;
    logic             w_alu_full;
    logic             w_lsb_full;
    logic             w_alu_empty;
    logic             w_lsb_empty;

    logic             w_alu_acc;
    logic             w_lsb_acc;
    logic             w_alu_byp;
    logic             w_lsb_byp;
    logic             w_alu_cand;
    logic             w_lsb_cand;
    logic             w_gnt_alu;
    logic             w_gnt_lsb;
    logic             w_alu_push;
    logic             w_lsb_push;
    logic             w_alu_pop;
    logic             w_lsb_pop;
    logic [PAY_W-1:0] w_alu_pay;
    logic [PAY_W-1:0] w_lsb_pay;

    prio_e            r_prio;
    logic             r_cdb_valid;
    logic [ROB_W-1:0] r_cdb_rob_id;
    logic [31:0]      r_cdb_value;

    assign alu_ready = (w_alu_count != CNT_W'(FIFO_DEPTH));
    assign lsb_ready = (w_lsb_count != CNT_W'(FIFO_DEPTH));

    assign w_alu_acc = alu_valid & ~w_alu_full & rdy_in;
    assign w_lsb_acc = lsb_valid & ~w_lsb_full & rdy_in;

`ifdef CDB_BYPASS_EN
    // Bypass only from an empty FIFO so per-source order is never violated.
    assign w_alu_byp = w_alu_empty & w_alu_acc;
    assign w_lsb_byp = w_lsb_empty & w_lsb_acc;
    assign w_alu_pay = w_alu_empty ? {alu_rob_id, alu_value} : w_alu_head;
    assign w_lsb_pay = w_lsb_empty ? {lsb_rob_id, lsb_value} : w_lsb_head;
`else
    assign w_alu_byp = 1'b0;
    assign w_lsb_byp = 1'b0;
    assign w_alu_pay = w_alu_head;
    assign w_lsb_pay = w_lsb_head;
`endif

    assign w_alu_cand = ~w_alu_empty | w_alu_byp;
    assign w_lsb_cand = ~w_lsb_empty | w_lsb_byp;

    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_lsb = 1'b0;
        if (rdy_in) begin
            if (w_alu_cand && w_lsb_cand) begin
                w_gnt_alu = (r_prio == PRIO_ALU);
                w_gnt_lsb = (r_prio == PRIO_LSB);
            end else begin
                w_gnt_alu = w_alu_cand;
                w_gnt_lsb = w_lsb_cand;
            end
        end
    end

    // A granted bypass goes straight to the bus and never occupies the FIFO.
    assign w_alu_push = w_alu_acc & ~(w_alu_byp & w_gnt_alu);
    assign w_lsb_push = w_lsb_acc & ~(w_lsb_byp & w_gnt_lsb);
    assign w_alu_pop  = w_gnt_alu & ~w_alu_empty;
    assign w_lsb_pop  = w_gnt_lsb & ~w_lsb_empty;

    cdb_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_flush (rob_clear),
        .i_push  (w_alu_push),
        .i_data  ({alu_rob_id, alu_value}),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_count (w_alu_count),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty)
    );

    cdb_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_lsb_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_flush (rob_clear),
        .i_push  (w_lsb_push),
        .i_data  ({lsb_rob_id, lsb_value}),
        .i_pop   (w_lsb_pop),
        .o_head  (w_lsb_head),
        .o_count (w_lsb_count),
        .o_full  (w_lsb_full),
        .o_empty (w_lsb_empty)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in || rob_clear) begin
            r_prio       <= PRIO_ALU;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_value  <= '0;
        end else if (rdy_in) begin
            if (w_gnt_alu) begin
                {r_cdb_rob_id, r_cdb_value} <= w_alu_pay;
                r_cdb_valid <= 1'b1;
                r_prio      <= prio_flip(PRIO_ALU);
            end else if (w_gnt_lsb) begin
                {r_cdb_rob_id, r_cdb_value} <= w_lsb_pay;
                r_cdb_valid <= 1'b1;
                r_prio      <= prio_flip(PRIO_LSB);
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign cdb_valid  = r_cdb_valid;
    assign cdb_rob_id = r_cdb_rob_id;
    assign cdb_value  = r_cdb_value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes the hand-derived
// broadcast order into a queue; a negedge monitor pops it on each fresh broadcast.
module tb_cdb_arbiter;

`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        rob_clear = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_rob_id = '0;
    logic [31:0] alu_value = '0;
    logic        alu_ready;
    logic        lsb_valid = 1'b0;
    logic [3:0]  lsb_rob_id = '0;
    logic [31:0] lsb_value = '0;
    logic        lsb_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;

    int n_checks = 0;
    int n_pass = 0;
    logic [35:0] sb[$];
    logic r_fresh = 1'b0;

    cdb_arbiter #(
        .ROB_W      (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rob_clear  (rob_clear),
        .alu_valid  (alu_valid),
        .alu_rob_id (alu_rob_id),
        .alu_value  (alu_value),
        .alu_ready  (alu_ready),
        .lsb_valid  (lsb_valid),
        .lsb_rob_id (lsb_rob_id),
        .lsb_value  (lsb_value),
        .lsb_ready  (lsb_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_exp(input logic [3:0] rob, input logic [31:0] val);
        sb.push_back({rob, val});
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
    endtask

    // A broadcast is new only if the edge that produced it was a rdy edge.
    always @(posedge clk_in) r_fresh <= rdy_in;

    always @(negedge clk_in) begin
        if (r_fresh && cdb_valid) begin
            if (sb.size() == 0) begin
                chk("cdb_unexpected", 64'({cdb_rob_id, cdb_value}), 64'h0);
            end else begin
                chk("cdb_payload", 64'({cdb_rob_id, cdb_value}), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int D;
        // Reset state.
        do_reset();
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_rob", 64'(cdb_rob_id), 64'd0);
        chk("rst_value", 64'(cdb_value), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_lsb_ready", 64'(lsb_ready), 64'd1);

        // Single ALU result latency.
        alu_valid = 1'b1; alu_rob_id = 4'd3; alu_value = 32'h11;
        push_exp(4'd3, 32'h11);
        cyc();
        alu_valid = 1'b0;
        chk("t1_edge_k", 64'(cdb_valid), 64'(BYP));
        cyc();
        chk("t1_edge_k1", 64'(cdb_valid), 64'(!BYP));
        cyc();
        chk("t1_edge_k2", 64'(cdb_valid), 64'd0);

        // Simultaneous pairs: ALU first at prio 0, LSB first after an odd grant.
        do_reset();
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = 32'hA;
        lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'hB;
        push_exp(4'd1, 32'hA); push_exp(4'd2, 32'hB);
        cyc();
        alu_valid = 1'b0; lsb_valid = 1'b0;
        idle(4);
        alu_valid = 1'b1; alu_rob_id = 4'd4; alu_value = 32'h44;
        push_exp(4'd4, 32'h44);
        cyc();
        alu_valid = 1'b0;
        idle(4);
        alu_valid = 1'b1; alu_rob_id = 4'd6; alu_value = 32'hC;
        lsb_valid = 1'b1; lsb_rob_id = 4'd7; lsb_value = 32'hD;
        push_exp(4'd7, 32'hD); push_exp(4'd6, 32'hC);
        cyc();
        alu_valid = 1'b0; lsb_valid = 1'b0;
        idle(4);

        // Both sources streaming: LSB FIFO fills and one result is dropped.
        do_reset();
        D = BYP ? 7 : 6;
        for (int i = 0; i < 6; i++) begin
            push_exp(4'(i), 32'hA000 + 32'(i));
            push_exp(4'(8 + i), 32'hB000 + 32'(i));
        end
        if (BYP) push_exp(4'd14, 32'hB006);
        for (int c = 0; c <= D; c++) begin
            alu_valid = (c < 6); alu_rob_id = 4'(c); alu_value = 32'hA000 + 32'(c);
            lsb_valid = 1'b1; lsb_rob_id = 4'(8 + c); lsb_value = 32'hB000 + 32'(c);
            chk("t3_lsb_ready", 64'(lsb_ready), 64'(c != D));
            chk("t3_alu_ready", 64'(alu_ready), 64'd1);
            cyc();
        end
        alu_valid = 1'b0; lsb_valid = 1'b0;
        idle(10);

        // Flush with entries pending in both FIFOs.
        do_reset();
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = 32'hC0;
        lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'hD0;
        push_exp(4'd1, 32'hC0);
        if (BYP) push_exp(4'd2, 32'hD0);
        cyc();
        alu_rob_id = 4'd3; alu_value = 32'hC1;
        lsb_rob_id = 4'd4; lsb_value = 32'hD1;
        cyc();
        rob_clear = 1'b1;
        alu_rob_id = 4'd5; alu_value = 32'hC2;
        lsb_rob_id = 4'd6; lsb_value = 32'hD2;
        cyc();
        rob_clear = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0;
        chk("t4_valid", 64'(cdb_valid), 64'd0);
        chk("t4_alu_ready", 64'(alu_ready), 64'd1);
        chk("t4_lsb_ready", 64'(lsb_ready), 64'd1);
        idle(6);

        // rdy_in stall while rob 5 is on the bus (prio restored by the flush).
        alu_valid = 1'b1; alu_rob_id = 4'd5; alu_value = 32'h55;
        lsb_valid = 1'b1; lsb_rob_id = 4'd9; lsb_value = 32'h99;
        push_exp(4'd5, 32'h55); push_exp(4'd9, 32'h99);
        cyc();
        alu_valid = 1'b0; lsb_valid = 1'b0;
        if (!BYP) cyc();
        chk("t5_pre_rob", 64'(cdb_rob_id), 64'd5);
        rdy_in = 1'b0;
        alu_valid = 1'b1; alu_rob_id = 4'd12; alu_value = 32'hEE;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_hold_valid", 64'(cdb_valid), 64'd1);
            chk("t5_hold_rob", 64'(cdb_rob_id), 64'd5);
            chk("t5_hold_value", 64'(cdb_value), 64'h55);
        end
        rdy_in = 1'b1; alu_valid = 1'b0;
        cyc();
        chk("t5_resume_rob", 64'(cdb_rob_id), 64'd9);
        cyc();
        chk("t5_after_valid", 64'(cdb_valid), 64'd0);
        idle(2);

        // Ten back-to-back ALU results wrap the FIFO pointers.
        for (int i = 0; i < 10; i++) begin
            alu_valid = 1'b1; alu_rob_id = 4'(i); alu_value = 32'h600 + 32'(i);
            push_exp(4'(i), 32'h600 + 32'(i));
            chk("t6_alu_ready", 64'(alu_ready), 64'd1);
            cyc();
        end
        alu_valid = 1'b0;
        idle(6);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
